mem_access_unit: RTL and testbench

- Parametrised load/store bus master sitting between the cpu controller/regfile and the ram.
- Replaces ad-hoc bus_addr/bus_data muxing with a request/response handshake.
- Supports byte/half/word/double accesses with byte enables, sign/zero extension, misalignment detection and ram wait states.
- One access in flight at a time.

---
 rtl/mem_access_unit_pkg.sv | 36 +++
 rtl/mem_access_unit_lane_align.sv | 54 +++++
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store bus master (mem_access_unit) and its
// lane-alignment helper (mau_lane_align).
//   size_e  : access size encoding used on req_size
//   err_e   : response error codes driven on rsp_err
//   state_e : mem_access_unit FSM states
//   misaligned() : natural-alignment check of a byte address for a size
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_TMO   = 2'd2
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // True when addr is not a multiple of the access size (2^size bytes).
  function automatic logic misaligned(input logic [2:0] addr_lo,
                                      input logic [1:0] size);
    logic [2:0] mask;
    mask = 3'((4'd1 << size) - 4'd1);
    return |(addr_lo & mask);
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mau_lane_align: purely combinational byte-lane steering for a bus of XLEN
// bits. Produces byte enables and lane-shifted store data for an access of
// 2^i_size bytes at lane offset i_off, and extracts/extends load data from
// the full-width read word.
// Ports:
//   i_size     access size (size_e)
//   i_unsigned 1 = zero-extend load data, 0 = sign-extend
//   i_off      byte offset within the bus word
//   i_wdata    right-justified store data
//   i_rdata    full-width read data from memory
//   o_be       byte enables
//   o_wdata    store data shifted into its lanes
//   o_rdata    load data, right-justified and extended to XLEN
module mau_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  size_e                       i_size,
  input  logic                        i_unsigned,
  input  logic [$clog2(XLEN/8)-1:0]   i_off,
  input  logic [XLEN-1:0]             i_wdata,
  input  logic [XLEN-1:0]             i_rdata,
  output logic [XLEN/8-1:0]           o_be,
  output logic [XLEN-1:0]             o_wdata,
  output logic [XLEN-1:0]             o_rdata
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned MSB_W = $clog2(XLEN);

  logic [OFF_W+2:0] w_shamt;
  logic [XLEN-1:0]  w_tmp;
  logic [XLEN-1:0]  w_keep;
  logic [6:0]       w_nbits;
  logic [MSB_W-1:0] w_msb;
  logic             w_sign;

  assign w_shamt = {i_off, 3'b000};

  // A full-width access overflows the shifted 1 to zero, so subtracting 1
  // yields an all-ones mask without a special case.
  assign o_be    = ((BE_W'(1) << (4'd1 << 2'(i_size))) - BE_W'(1)) << i_off;
  assign o_wdata = i_wdata << w_shamt;

  assign w_tmp   = i_rdata >> w_shamt;
  assign w_nbits = 7'd8 << 2'(i_size);
  assign w_keep  = (XLEN'(1) << w_nbits) - XLEN'(1);
  assign w_msb   = MSB_W'(w_nbits - 7'd1);
  assign w_sign  = ~i_unsigned & w_tmp[w_msb];
  assign o_rdata = (w_tmp & w_keep) | ({XLEN{w_sign}} & ~w_keep);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store bus master between the CPU controller and RAM.
// Accepts one request at a time via a valid/ready handshake, drives a RAM
// cycle with byte enables and lane-shifted data, waits for ram_ready, and
// returns extended load data or an error as a one-cycle response pulse.
// Misaligned requests (and doubles on a 32-bit bus) respond with an alignment
// error without touching the RAM.
// Build option: define MAU_TIMEOUT_EN to abort a RAM access that has seen no
// ram_ready for TIMEOUT cycles (response error code 2).
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata  request fields
//   rsp_valid, rsp_rdata, rsp_err                        response
//   ram_addr, ram_wdata, ram_be, ram_cs, ram_we, ram_oe  RAM drive
//   ram_rdata, ram_ready                                 RAM return
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  input  logic [XLEN-1:0]   ram_rdata,
  output logic [XLEN/8-1:0] ram_be,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  input  logic              ram_ready
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  if (!(XLEN == 32 || XLEN == 64) || TIMEOUT == 0) begin : g_param_check
    $error("mem_access_unit: XLEN must be 32 or 64 and TIMEOUT nonzero");
  end

  state_e            r_state, w_next;
  logic              r_we;
  logic              r_unsigned;
  size_e             r_size;
  logic [OFF_W-1:0]  r_off;
  logic [XLEN-1:0]   r_rdata;
  err_e              r_err;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [BE_W-1:0]   r_ram_be;
  logic [XLEN-1:0]   r_ram_wdata;

  logic              w_bad;
  logic              w_tmo;
  size_e             w_lane_size;
  logic [OFF_W-1:0]  w_lane_off;
  logic [ADDR_W-1:0] w_lane_addr;
  logic [BE_W-1:0]   w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_rdata;

  assign w_bad = misaligned(req_addr[2:0], req_size) ||
                 (req_size == SZ_D && XLEN == 32);

  always_comb begin
    w_lane_addr = req_addr;
    w_lane_addr[OFF_W-1:0] = '0;
  end

  // One aligner serves both directions: in IDLE it shapes the incoming store,
  // afterwards it decodes read data using the latched size/offset.
  assign w_lane_size = (r_state == ST_IDLE) ? size_e'(req_size) : r_size;
  assign w_lane_off  = (r_state == ST_IDLE) ? req_addr[OFF_W-1:0] : r_off;

  mau_lane_align #(.XLEN(XLEN)) u_lane (
    .i_size     (w_lane_size),
    .i_unsigned (r_unsigned),
    .i_off      (w_lane_off),
    .i_wdata    (req_wdata),
    .i_rdata    (ram_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata)
  );

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state != ST_ACCESS) begin
      r_tmo_cnt <= '0;
    end else if (!ram_ready) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Fires on the cycle the count would reach TIMEOUT; ram_ready takes priority.
  assign w_tmo = (r_state == ST_ACCESS) && !ram_ready &&
                 (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_oe    = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_bad ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        ram_cs = 1'b1;
        ram_we = r_we;
        ram_oe = ~r_we;
        if (ram_ready || w_tmo) w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= SZ_B;
      r_off       <= '0;
      r_rdata     <= '0;
      r_err       <= ERR_OK;
      r_ram_addr  <= '0;
      r_ram_be    <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= size_e'(req_size);
            r_unsigned <= req_unsigned;
            r_off      <= req_addr[OFF_W-1:0];
            r_rdata    <= '0;
            r_err      <= w_bad ? ERR_ALIGN : ERR_OK;
            if (!w_bad) begin
              r_ram_addr  <= w_lane_addr;
              r_ram_be    <= w_be;
              r_ram_wdata <= w_wdata;
            end
          end
        end
        ST_ACCESS: begin
          if (ram_ready) begin
            r_rdata     <= r_we ? '0 : w_rdata;
            r_ram_addr  <= '0;
            r_ram_be    <= '0;
            r_ram_wdata <= '0;
          end else if (w_tmo) begin
            r_err       <= ERR_TMO;
            r_ram_addr  <= '0;
            r_ram_be    <= '0;
            r_ram_wdata <= '0;
          end
        end
        ST_RESP: begin
          r_rdata <= '0;
          r_err   <= ERR_OK;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign ram_addr  = r_ram_addr;
  assign ram_be    = r_ram_be;
  assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN = 64). A byte-level model predicts
// every request's lanes, data, error and timing; one compare process checks
// the DUT each cycle and also plays the RAM (ram_ready after t_wait cycles).
module tb_mem_access_unit;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 64;
  localparam int          TMO  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic          rsp_valid;
  logic [63:0]   rsp_rdata;
  logic [1:0]    rsp_err;
  logic [AW-1:0] ram_addr;
  logic [63:0]   ram_wdata, ram_rdata;
  logic [7:0]    ram_be;
  logic          ram_cs, ram_we, ram_oe;
  logic          ram_ready = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(XLEN), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_be(ram_be), .ram_cs(ram_cs),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_ready(ram_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Current transaction and its model predictions.
  logic        t_we;
  logic [63:0] e_addr, e_wdata, e_rdata;
  logic [7:0]  e_be;
  logic [1:0]  e_err;
  int          t_wait, acc_cycles;

  // Hand-computed literal expectations for the current transaction.
  bit          lit_en = 1'b0;
  logic [63:0] lit_rdata, lit_addr, lit_wdata;
  logic [1:0]  lit_err;
  logic [7:0]  lit_be;
  int          lit_lat;

  function automatic int nbytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic logic [1:0] m_err(input logic [1:0] s, input logic [63:0] a);
    return ((int'(a[2:0]) % nbytes(s)) != 0) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [7:0] m_be(input logic [1:0] s, input logic [63:0] a);
    logic [7:0] r;
    int off;
    r = '0;
    off = int'(a[2:0]);
    for (int b = 0; b < 8; b++)
      if (b >= off && b < off + nbytes(s)) r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [1:0] s, input logic [63:0] a,
                                          input logic [63:0] w);
    logic [63:0] r;
    int off;
    r = '0;
    off = int'(a[2:0]);
    for (int k = 0; k < nbytes(s); k++)
      if (off + k < 8) r[8*(off+k) +: 8] = w[8*k +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_rdata(input logic [1:0] s, input logic u,
                                          input logic [63:0] a, input logic [63:0] d);
    logic [63:0] v;
    int off, nb;
    v = '0;
    off = int'(a[2:0]);
    nb = nbytes(s);
    for (int k = 0; k < nb; k++)
      if (off + k < 8) v[8*k +: 8] = d[8*(off+k) +: 8];
    if (!u && nb < 8 && v[8*nb-1])
      for (int k = nb; k < 8; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process + RAM responder, sampling at the falling edge.
  initial begin : compare
    int  rel;
    bit  active;
    bit  exp_cs, exp_rsp;
    rel = 0;
    active = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        active    = 1'b0;
        ram_ready = 1'b0;
        chk("rst_cs", 64'(ram_cs), 64'd0);
        chk("rst_we", 64'(ram_we), 64'd0);
        chk("rst_oe", 64'(ram_oe), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_be", 64'(ram_be), 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
      end else if (active) begin
        rel++;
        exp_cs  = (rel <= acc_cycles);
        exp_rsp = (rel == acc_cycles + 1);
        chk("ram_cs", 64'(ram_cs), 64'(exp_cs));
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        if (exp_cs) begin
          chk("ram_addr", ram_addr, e_addr);
          chk("ram_be", 64'(ram_be), 64'(e_be));
          chk("ram_we", 64'(ram_we), 64'(t_we));
          chk("ram_oe", 64'(ram_oe), 64'(!t_we));
          if (t_we) chk("ram_wdata", ram_wdata, e_wdata);
          if (lit_en && rel == 1) begin
            chk("lit_be", 64'(ram_be), 64'(lit_be));
            chk("lit_addr", ram_addr, lit_addr);
            if (t_we) chk("lit_wdata", ram_wdata, lit_wdata);
          end
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (exp_rsp) begin
          chk("rsp_rdata", rsp_rdata, e_rdata);
          chk("rsp_err", 64'(rsp_err), 64'(e_err));
          if (lit_en) begin
            chk("lit_rdata", rsp_rdata, lit_rdata);
            chk("lit_err", 64'(rsp_err), 64'(lit_err));
            chk("lit_latency", 64'(rel), 64'(lit_lat));
          end
        end
        if (rel > acc_cycles) active = 1'b0;
        ram_ready = exp_cs && (rel == t_wait + 1);
      end else begin
        ram_ready = 1'b0;
        chk("idle_cs", 64'(ram_cs), 64'd0);
        chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        if (req_valid) begin
          active = 1'b1;
          rel = 0;
        end
      end
    end
  end

  task automatic pin(input logic [63:0] rdata, input logic [1:0] err, input int lat,
                     input logic [7:0] be, input logic [63:0] addr, input logic [63:0] wdata);
    lit_rdata = rdata;
    lit_err   = err;
    lit_lat   = lat;
    lit_be    = be;
    lit_addr  = addr;
    lit_wdata = wdata;
    lit_en    = 1'b1;
  endtask

  // Called #2 after a rising edge: sets model predictions and drives the request.
  task automatic setup(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] ram, input int wait_cyc);
    bit bad, tmo;
    bad = (m_err(size, addr) != 2'd0);
    tmo = 1'b0;
`ifdef MAU_TIMEOUT_EN
    if (!bad && wait_cyc >= TMO) tmo = 1'b1;
`endif
    t_we       = we;
    t_wait     = wait_cyc;
    acc_cycles = bad ? 0 : (tmo ? TMO : wait_cyc + 1);
    e_err      = bad ? 2'd1 : (tmo ? 2'd2 : 2'd0);
    e_addr     = {addr[63:3], 3'b000};
    e_be       = m_be(size, addr);
    e_wdata    = m_wdata(size, addr, wdata);
    e_rdata    = (bad || tmo || we) ? 64'd0 : m_rdata(size, uns, addr, ram);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    ram_rdata    = ram;
    req_valid    = 1'b1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] ram, input int wait_cyc);
    @(posedge clk); #2;
    setup(we, size, uns, addr, wdata, ram, wait_cyc);
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (acc_cycles + 3) @(posedge clk);
    lit_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; ram_rdata = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // sd 0x10, immediate ready
    pin(64'h0, 2'd0, 2, 8'hFF, 64'h10, 64'h1122334455667788);
    issue(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 64'h0, 0);
    // lb / lbu 0x13
    pin(64'hFFFFFFFFFFFFFF80, 2'd0, 2, 8'h08, 64'h10, 64'h0);
    issue(1'b0, 2'd0, 1'b0, 64'h13, 64'h0, 64'h0000000080000000, 0);
    pin(64'h80, 2'd0, 2, 8'h08, 64'h10, 64'h0);
    issue(1'b0, 2'd0, 1'b1, 64'h13, 64'h0, 64'h0000000080000000, 0);
    // sh 0x21 misaligned: no RAM cycle, response next cycle
    pin(64'h0, 2'd1, 1, 8'h00, 64'h0, 64'h0);
    issue(1'b1, 2'd1, 1'b0, 64'h21, 64'h5555, 64'h0, 0);
    // sw 0x24: upper lanes
    pin(64'h0, 2'd0, 2, 8'hF0, 64'h20, 64'hDEADBEEF00000000);
    issue(1'b1, 2'd2, 1'b0, 64'h24, 64'h00000000DEADBEEF, 64'h0, 0);
    // lw 0x24 with 5 wait states, then lwu without
    pin(64'hFFFFFFFF89ABCDEF, 2'd0, 7, 8'hF0, 64'h20, 64'h0);
    issue(1'b0, 2'd2, 1'b0, 64'h24, 64'h0, 64'h89ABCDEF00000000, 5);
    pin(64'h0000000089ABCDEF, 2'd0, 2, 8'hF0, 64'h20, 64'h0);
    issue(1'b0, 2'd2, 1'b1, 64'h24, 64'h0, 64'h89ABCDEF00000000, 0);
    // halfwords
    pin(64'h7FFF, 2'd0, 3, 8'hC0, 64'h0, 64'h0);
    issue(1'b0, 2'd1, 1'b0, 64'h06, 64'h0, 64'h7FFF000000000000, 1);
    pin(64'hFFFFFFFFFFFF8001, 2'd0, 2, 8'hC0, 64'h100, 64'h0);
    issue(1'b0, 2'd1, 1'b0, 64'h106, 64'h0, 64'h8001000000000000, 0);
    pin(64'h8001, 2'd0, 2, 8'hC0, 64'h100, 64'h0);
    issue(1'b0, 2'd1, 1'b1, 64'h106, 64'h0, 64'h8001000000000000, 0);
    pin(64'h0, 2'd0, 2, 8'hC0, 64'h38, 64'h1234000000000000);
    issue(1'b1, 2'd1, 1'b0, 64'h3E, 64'h1234, 64'h0, 0);
    // ld passes through, sb top lane
    pin(64'hCAFEBABE12345678, 2'd0, 2, 8'hFF, 64'h18, 64'h0);
    issue(1'b0, 2'd3, 1'b0, 64'h18, 64'h0, 64'hCAFEBABE12345678, 0);
    pin(64'h0, 2'd0, 2, 8'h80, 64'h0, 64'hAB00000000000000);
    issue(1'b1, 2'd0, 1'b0, 64'h07, 64'hAB, 64'h0, 0);
    // more misaligned cases
    pin(64'h0, 2'd1, 1, 8'h00, 64'h0, 64'h0);
    issue(1'b0, 2'd3, 1'b0, 64'h1C, 64'h0, 64'hFFFFFFFFFFFFFFFF, 0);
    pin(64'h0, 2'd1, 1, 8'h00, 64'h0, 64'h0);
    issue(1'b0, 2'd2, 1'b0, 64'h22, 64'h0, 64'hFFFFFFFFFFFFFFFF, 0);

    // reset in the middle of a long access
    @(posedge clk); #2;
    setup(1'b0, 2'd2, 1'b0, 64'h40, 64'h0, 64'h1, 50);
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (4) @(posedge clk);

    // recovery after reset
    pin(64'h1122334455667788, 2'd0, 3, 8'hFF, 64'h48, 64'h0);
    issue(1'b0, 2'd3, 1'b0, 64'h48, 64'h0, 64'h1122334455667788, 1);

`ifdef MAU_TIMEOUT_EN
    // no ready: abort after TMO ACCESS cycles
    pin(64'h0, 2'd2, TMO + 1, 8'h0F, 64'h40, 64'h0);
    issue(1'b0, 2'd2, 1'b0, 64'h40, 64'h0, 64'h12345678, 100);
    // ready on the last allowed cycle wins
    pin(64'h12345678, 2'd0, TMO + 1, 8'h0F, 64'h40, 64'h0);
    issue(1'b0, 2'd2, 1'b0, 64'h40, 64'h0, 64'h12345678, TMO - 1);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
